// File: rtl/byte_receiver.sv
// Serial-to-parallel word receiver.
// Shifts in one bit per enabled clock, MSB first. When a complete word has
// been captured it is published on out with a one-cycle done pulse. If
// enable drops while a partial word is pending, that partial word is thrown
// away and aborted pulses for one cycle.
module byte_receiver #(
  parameter int unsigned WIDTH = 32,
  localparam int unsigned CW = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             in,
  output logic [WIDTH-1:0] out,
  output logic             done,
  output logic             aborted,
  output logic [CW-1:0]    bit_count
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  // Count value on the edge that captures the final bit of a word
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  logic [0:0]       state;
  logic [0:0]       state_n;
  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] shift_n;
  logic [WIDTH-1:0] out_n;
  logic [CW-1:0]    count_n;
  logic             done_n;
  logic             aborted_n;
  logic [WIDTH-1:0] shifted;

  // Shift register contents after taking the current serial bit
  assign shifted = {shift_reg[WIDTH-2:0], in};

  // Next-state and next-output logic
  always_comb begin
    state_n   = state;
    shift_n   = shift_reg;
    out_n     = out;
    count_n   = bit_count;
    done_n    = 1'b0;
    aborted_n = 1'b0;

    if (enable) begin
      state_n = SHIFT;
      shift_n = shifted;
      if (bit_count == LAST_BIT) begin
        // Final bit: publish the word and start the next one immediately
        out_n   = shifted;
        done_n  = 1'b1;
        count_n = '0;
      end else begin
        count_n = bit_count + CW'(1);
      end
    end else begin
      state_n = IDLE;
      count_n = '0;
      // Only a word actually in progress counts as aborted
      if ((state == SHIFT) && (bit_count != '0)) begin
        aborted_n = 1'b1;
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      shift_reg <= '0;
      out       <= '0;
      bit_count <= '0;
      done      <= 1'b0;
      aborted   <= 1'b0;
    end else begin
      state     <= state_n;
      shift_reg <= shift_n;
      out       <= out_n;
      bit_count <= count_n;
      done      <= done_n;
      aborted   <= aborted_n;
    end
  end

endmodule

// File: tb/tb_byte_receiver.sv
// Bench for byte_receiver: table of word/partial-word vectors, a scoreboard
// queue of expected completed words, and hand sequences for streaming,
// asynchronous reset and randomized loopback.
module tb_byte_receiver;

  localparam int unsigned W  = 32;
  localparam int unsigned CW = $clog2(W) + 1;

  logic          clk;
  logic          reset;
  logic          enable;
  logic          din;
  logic [W-1:0]  out;
  logic          done;
  logic          aborted;
  logic [CW-1:0] bit_count;

  int total;
  int bad;
  int exp_aborts;
  int abort_seen;

  logic [W-1:0] sb[$];
  logic [W-1:0] prev_out;

  typedef struct {
    logic [63:0] word;
    int          nbits;
    logic [63:0] exp_out;
    logic        exp_abort;
  } vec_t;

  vec_t vecs[8];

  byte_receiver #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .in        (din),
    .out       (out),
    .done      (done),
    .aborted   (aborted),
    .bit_count (bit_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Drive nbits of word MSB-first with enable high; checks done and count each edge
  task automatic send_bits(input logic [63:0] word, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      enable = 1'b1;
      din    = word[W-1-i];
      if (i == int'(W) - 1) sb.push_back(word[W-1:0]);
      @(posedge clk);
      #1;
      chk("done_edge", 64'(done), 64'(i == int'(W) - 1));
      chk("count_edge", 64'(bit_count), 64'((i + 1) % int'(W)));
    end
  endtask

  // One edge with enable low
  task automatic idle(input logic exp_abort);
    enable = 1'b0;
    din    = 1'b0;
    if (exp_abort) exp_aborts++;
    @(posedge clk);
    #1;
    chk("idle_abort", 64'(aborted), 64'(exp_abort));
    chk("idle_done", 64'(done), 64'd0);
    chk("idle_count", 64'(bit_count), 64'd0);
  endtask

  // Monitor: scoreboard pop on done, exclusivity, out stability between words
  always @(negedge clk) begin
    if (!reset) begin
      chk("done_abort_excl", 64'(done & aborted), 64'd0);
      if (aborted) abort_seen++;
      if (done) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected_done", 64'd1, 64'd0);
        end else begin
          chk("sb_out", 64'(out), 64'(sb.pop_front()));
        end
      end else if (out !== prev_out) begin
        chk("out_stable", 64'(out), 64'(prev_out));
      end
    end
    prev_out = out;
  end

  initial begin
    total      = 0;
    bad        = 0;
    exp_aborts = 0;
    abort_seen = 0;
    reset      = 1'b1;
    enable     = 1'b0;
    din        = 1'b0;

    vecs[0] = '{64'hDEADBEEF, 32, 64'hDEADBEEF, 1'b0};
    vecs[1] = '{64'hA5A5A5A5, 32, 64'hA5A5A5A5, 1'b0};
    vecs[2] = '{64'h12345678, 10, 64'hA5A5A5A5, 1'b1};
    vecs[3] = '{64'h0000FFFF, 32, 64'h0000FFFF, 1'b0};
    vecs[4] = '{64'hFFFFFFFF, 32, 64'hFFFFFFFF, 1'b0};
    vecs[5] = '{64'h00000001, 31, 64'hFFFFFFFF, 1'b1};
    vecs[6] = '{64'h80000000,  1, 64'hFFFFFFFF, 1'b1};
    vecs[7] = '{64'h00000001, 32, 64'h00000001, 1'b0};

    // Reset state, held across clock edges with enable high
    #12;
    enable = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_out", 64'(out), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_abort", 64'(aborted), 64'd0);
    chk("rst_count", 64'(bit_count), 64'd0);
    enable = 1'b0;
    #2;
    reset = 1'b0;

    // Table-driven vectors: word or partial word, then two idle edges
    for (int v = 0; v < 8; v++) begin
      send_bits(vecs[v].word, vecs[v].nbits);
      chk("vec_out", 64'(out), vecs[v].exp_out);
      chk("vec_count", 64'(bit_count), 64'(vecs[v].nbits % int'(W)));
      idle(vecs[v].exp_abort);
      chk("vec_out_idle", 64'(out), vecs[v].exp_out);
      idle(1'b0);
    end

    // Back-to-back words with no gap edge
    send_bits(64'h12345678, 32);
    chk("b2b_out1", 64'(out), 64'h12345678);
    send_bits(64'h9ABCDEF0, 32);
    chk("b2b_out2", 64'(out), 64'h9ABCDEF0);

    // Enable dropped for exactly one edge right after done: no abort
    idle(1'b0);
    send_bits(64'hFFFFFFFF, 32);
    chk("gap_out", 64'(out), 64'hFFFFFFFF);

    // Asynchronous reset mid-word at bit_count = 20
    send_bits(64'hCAFEBABE, 20);
    chk("pre_rst_count", 64'(bit_count), 64'd20);
    enable = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("async_out", 64'(out), 64'd0);
    chk("async_count", 64'(bit_count), 64'd0);
    chk("async_done", 64'(done), 64'd0);
    chk("async_abort", 64'(aborted), 64'd0);
    @(posedge clk);
    #3;
    reset = 1'b0;
    send_bits(64'h0000FFFF, 32);
    chk("post_rst_out", 64'(out), 64'h0000FFFF);
    idle(1'b0);

    // Loopback-style random words with random idle gaps between them
    for (int n = 0; n < 100; n++) begin
      logic [63:0] w;
      int          gap;
      w   = 64'($urandom);
      gap = int'($urandom_range(0, 2));
      send_bits(w, 32);
      for (int g = 0; g < gap; g++) idle(1'b0);
    end
    idle(1'b0);
    idle(1'b0);

    chk("sb_drained", 64'(sb.size()), 64'd0);
    chk("abort_total", 64'(abort_seen), 64'(exp_aborts));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
